// File: rtl/gmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmii_pkg
// Description : Shared types and constants for the GMII TX arbiter slice.
//               GMII_DATA_W - byte lane width of the TX stream
//               GRANT_W     - width of the grant index (up to 8 sources)
//               arb_state_t - arbiter state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package gmii_pkg;

    localparam int GMII_DATA_W = 8;
    localparam int GRANT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/gmii_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gmii_rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               requesting port found when searching upward from
//               last_grant+1, wrapping at NUM_PORTS. The port named by
//               last_grant is therefore searched last.
// Ports       : req        - per-port request vector
//               last_grant - most recently served port
//               found      - at least one request is present
//               index      - winning port (0 when found=0)
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_rr_pick
    import gmii_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GRANT_W-1:0]   last_grant,
    output logic                 found,
    output logic [GRANT_W-1:0]   index
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester,
    // written last, wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req[i] && (cand == i)) begin
                    found = 1'b1;
                    index = GRANT_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_arbiter
// Description : Frame-level round-robin arbiter sharing one 8-bit
//               AXI-Stream TX path between NUM_PORTS sources. A grant is
//               held from the first beat to the accepted tlast beat, and the
//               output is a single register stage.
//               Optional macro GMII_TX_ARB_TIMEOUT_EN adds a mid-frame
//               starvation timeout that terminates the frame with a 0x00
//               tlast beat and discards the remainder of the source frame.
// Ports       : aclk, areset          - clock, synchronous active-high reset
//               s_tdata/tvalid/tlast  - source streams (port i: bits 8i+7:8i)
//               s_tready              - per-source ready
//               m_tdata/tvalid/tlast  - registered output stream
//               m_tready              - downstream ready
//               grant_id              - granted port, valid while busy
//               busy                  - high while passing a frame
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_arbiter
    import gmii_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [GMII_DATA_W*NUM_PORTS-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    output logic [NUM_PORTS-1:0]             s_tready,
    output logic [GMII_DATA_W-1:0]           m_tdata,
    output logic                             m_tvalid,
    output logic                             m_tlast,
    input  logic                             m_tready,
    output logic [GRANT_W-1:0]               grant_id,
    output logic                             busy
);

    arb_state_t             state_q, state_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [GRANT_W-1:0]     last_grant_q, last_grant_d;
    logic [GMII_DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;

    logic                   w_pick_found;
    logic [GRANT_W-1:0]     w_pick_idx;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [GMII_DATA_W-1:0] w_sel_data;
    logic                   w_out_free;

`ifdef GMII_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    gmii_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req        (s_tvalid),
        .last_grant (last_grant_q),
        .found      (w_pick_found),
        .index      (w_pick_idx)
    );

    // Granted-port mux
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
                w_sel_data  = s_tdata[i*GMII_DATA_W +: GMII_DATA_W];
            end
        end
    end

    // The output register can take a new beat when empty or draining now.
    assign w_out_free = !m_tvalid_q || m_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        s_tready     = '0;
`ifdef GMII_TX_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        // Drain by default; a fresh load below overrides this.
        if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_pick_found) begin
                    grant_d      = w_pick_idx;
                    last_grant_d = w_pick_idx;
                    state_d      = PASS;
                end
            end
            PASS: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    s_tready[i] = (grant_q == GRANT_W'(i)) && w_out_free;
                end
                if (w_sel_valid && w_out_free) begin
                    m_tdata_d  = w_sel_data;
                    m_tlast_d  = w_sel_last;
                    m_tvalid_d = 1'b1;
                    if (w_sel_last) begin
                        state_d = IDLE;
                    end
                end
`ifdef GMII_TX_ARB_TIMEOUT_EN
                // Count only while the source is silent and nothing is
                // waiting in the output register.
                else if (!w_sel_valid && !m_tvalid_q) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        m_tdata_d  = '0;
                        m_tlast_d  = 1'b1;
                        m_tvalid_d = 1'b1;
                        state_d    = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef GMII_TX_ARB_TIMEOUT_EN
            FLUSH: begin
                // Swallow the rest of the abandoned source frame.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    s_tready[i] = (grant_q == GRANT_W'(i));
                end
                if (w_sel_valid && w_sel_last) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_PORTS - 1);
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
`ifdef GMII_TX_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
`ifdef GMII_TX_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == PASS);

endmodule
`default_nettype wire

// File: doc/gmii_tx_arbiter.md
Name: gmii_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single 8-bit AXI-Stream TX path in front of the GMII interface between NUM_PORTS frame sources.
- A grant is held for a whole frame, from first beat to the accepted tlast beat, so frames never interleave.
- Output is one registered stage driving the GMII interface's tx_tdata/tx_tvalid/tx_tlast/tx_tready.
- Downstream IFG back-pressure (tready low) is honoured without data loss.

Parameters:
- NUM_PORTS, 2, number of requesting sources (2..8).
- TIMEOUT_CYCLES, 256, mid-frame starvation limit in cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_tdata  in  8*NUM_PORTS  source data; port i occupies bits [8i+7:8i].
- s_tvalid  in  NUM_PORTS  per-source valid.
- s_tlast  in  NUM_PORTS  per-source end of frame.
- s_tready  out  NUM_PORTS  per-source ready.
- m_tdata  out  8  data to the GMII TX stream.
- m_tvalid  out  1  valid to the GMII TX stream.
- m_tlast  out  1  end of frame to the GMII TX stream.
- m_tready  in  1  ready from the GMII TX stream.
- grant_id  out  3  index of the currently granted port; valid while busy=1.
- busy  out  1  high while in PASS.

Behaviour:
- Interface (already decided): one clock, aclk; reset areset is synchronous and active-high.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, busy=0, grant_id=0, state=IDLE, last_grant=NUM_PORTS-1 (port 0 wins first).
- Reset asserted mid-frame aborts immediately. The partial frame is not terminated; the downstream MAC handles the truncated frame.
- IDLE: each cycle, pick the first port with s_tvalid=1, searching from last_grant+1 with wrap at NUM_PORTS.
  - If one is found: grant_id<=it, last_grant<=it, go to PASS.
  - Otherwise stay in IDLE.
- Arbitration costs exactly one cycle. s_tready is all-zero in IDLE.
- PASS: s_tready[grant_id] = (!m_tvalid || m_tready); all other bits are 0.
- On a source handshake: m_tdata/m_tlast/m_tvalid are loaded from the granted port on the next edge (latency 1). Otherwise, if m_tready=1, m_tvalid<=0.
- Throughput: 1 beat/cycle while m_tready=1. No bubbles are inserted inside a frame.
- PASS -> IDLE on the cycle the granted port's tlast beat is handshaken. The next grant decision happens the following cycle.
  - Gap between frames is therefore at least 1 cycle; downstream IFG handling is unaffected.
- Simultaneous requests: rotating priority only. A port that was just served has lowest priority.
- Single active requester: it is re-granted every frame.
- Requests that go valid during PASS wait and are never dropped.
- s_tvalid dropping low mid-frame: the arbiter stays in PASS and outputs m_tvalid=0. Sources must supply contiguous frames.
- m_tready low: the output register holds; the source is stalled via s_tready. No beat is lost or duplicated.
- Unused grant_id bits are 0.

Optional Feature:
- Macro GMII_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive PASS cycles with s_tvalid[grant_id]=0 and the output register empty. It resets on any source beat.
  - When the count reaches TIMEOUT_CYCLES, the arbiter emits one beat m_tdata=0x00, m_tlast=1, then enters FLUSH.
  - FLUSH: s_tready[grant_id]=1; source beats are discarded, nothing is output. On the discarded tlast, go to IDLE.
  - areset clears FLUSH.
- Undefined: no counter, no FLUSH state; a stalled source holds the grant indefinitely.

Decomposition:
- Package gmii_pkg:
  - GMII_DATA_W=8.
  - State enum {IDLE, PASS, FLUSH}.
  - Grant index width constant GRANT_W=3.
- Sub-module gmii_rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_PORTS], last_grant.
  - Outputs: found, index.
- All arbiter state lives in gmii_tx_arbiter.

Test Plan:
- Single port 0 sends 64-byte frame 0x00..0x3F, m_tready=1 -> m_* shows the same 64 bytes on consecutive cycles, tlast on 0x3F, first beat 2 cycles after s_tvalid rises.
- Ports 0 and 1 both valid with continuous 4-byte frames (0xA0-A3, 0xB0-B3) -> output alternates A,B,A,B frames, never interleaved within a frame; grant_id toggles 0,1,0,1.
- m_tready held low 12 cycles mid-frame -> m_tdata frozen, s_tready low, zero loss; byte sequence resumes intact.
- Port 1 requests while port 0 is mid-frame -> port 1 is granted only after port 0's tlast handshake, exactly 1 idle cycle between frames.
- areset pulsed mid-frame -> next cycle m_tvalid=0, busy=0; port 0 wins the next simultaneous request.
- With GMII_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, port 0 stalls after 5 bytes -> after 16 idle cycles an extra beat 0x00 with m_tlast=1 is emitted; the rest of port 0's frame is swallowed; port 1 is then served normally.
